// File: rtl/alu_seq_pkg.sv
// Shared widths, opcode encodings and FSM state type for the ALU command sequencer.
package alu_seq_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned RES_W = 8;
  localparam int unsigned OP_W  = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;
  localparam logic [OP_W-1:0] OP_MUL = 3'b100;
  localparam logic [OP_W-1:0] OP_DIV = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  // Opcodes 110 and 111 have no ALU meaning.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response valid/ready bundle between a host and the ALU command sequencer.
interface alu_cmd_sequencer_if;
  import alu_seq_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [NIB_W-1:0] cmd_a;
  logic [NIB_W-1:0] cmd_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_data;
  logic [OP_W-1:0]  rsp_op;
  logic             rsp_err;

  // Host side: issues commands, consumes responses.
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_op, rsp_err
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_op, rsp_err
  );

endinterface

// File: rtl/alu_seq_fifo.sv
// Show-ahead synchronous FIFO holding queued {op,a,b} commands.
module alu_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr_q];
  assign count   = count_q;

  // Storage has no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives them one at a time onto the ALU pins and returns results in order.
// Optional feature macro: ALU_DIV_GUARD_EN (divide by zero answered locally, never issued).
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_cmd_sequencer_if.slave       bus,
  output logic [2*NIB_W-1:0]       alu_ui,
  output logic [OP_W-1:0]          alu_op,
  input  logic [RES_W-1:0]         alu_result,
  output logic                     busy
);

  localparam int unsigned ENT_W = OP_W + 2 * NIB_W;
  localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_e               state_q;
  logic [ENT_W-1:0]     head;
  logic                 full, empty, pop;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [OP_W-1:0]      head_op;
  logic [NIB_W-1:0]     head_a, head_b;
  logic                 div0, skip_now;

  logic [OP_W-1:0]      cur_op_q;
  logic                 skip_q;
  logic [RES_W-1:0]     skip_data_q;
  logic [CNT_W-1:0]     wait_cnt_q;
  logic                 rsp_valid_q, rsp_err_q;
  logic [RES_W-1:0]     rsp_data_q;
  logic [OP_W-1:0]      rsp_op_q;
  logic [2*NIB_W-1:0]   alu_ui_q;
  logic [OP_W-1:0]      alu_op_q;

  assign {head_op, head_a, head_b} = head;

`ifdef ALU_DIV_GUARD_EN
  assign div0 = (head_op == OP_DIV) && (head_b == '0);
`else
  assign div0 = 1'b0;
`endif

  // Commands answered without touching the ALU.
  assign skip_now = op_illegal(head_op) | div0;

  // Next command leaves the queue when the FSM is free or its response is being taken.
  assign pop = ~empty & ((state_q == StIdle) | ((state_q == StResp) & bus.rsp_ready));

  alu_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.cmd_valid),
    .wdata ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign bus.cmd_ready = ~full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_op    = rsp_op_q;
  assign bus.rsp_err   = rsp_err_q;
  assign alu_ui        = alu_ui_q;
  assign alu_op        = alu_op_q;
  assign busy          = (state_q != StIdle) | (fifo_count != '0);

  // Sequencer FSM with registered ALU pins and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_op_q    <= '0;
      skip_q      <= 1'b0;
      skip_data_q <= '0;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
      rsp_err_q   <= 1'b0;
      alu_ui_q    <= '0;
      alu_op_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) state_q <= StIssue;
        end
        StIssue: begin
          if (skip_q) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= skip_data_q;
            rsp_op_q    <= cur_op_q;
            rsp_err_q   <= 1'b1;
            state_q     <= StResp;
          end else begin
            wait_cnt_q <= CNT_W'(ALU_LAT - 1);
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (wait_cnt_q == '0) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= alu_result;
            rsp_op_q    <= cur_op_q;
            rsp_err_q   <= 1'b0;
            state_q     <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q - CNT_W'(1);
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= pop ? StIssue : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Capture the popped command; skipped commands leave the ALU pins untouched.
      if (pop) begin
        cur_op_q    <= head_op;
        skip_q      <= skip_now;
        skip_data_q <= div0 ? {RES_W{1'b1}} : '0;
        if (!skip_now) begin
          alu_ui_q <= {head_a, head_b};
          alu_op_q <= head_op;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a registered ALU model of ALU_LAT stages.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ALU_LAT = 1;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_ui, alu_result;
  logic [2:0] alu_op;
  logic       busy;
  logic [7:0] pipe [ALU_LAT];

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   rand_on = 0;

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(
    .DEPTH   (DEPTH),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_ui     (alu_ui),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference ALU arithmetic on plain integers.
  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [3:0] a, b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0:    return 8'(ia & ib);
      3'd1:    return 8'(ia | ib);
      3'd2:    return 8'((ia + ib) % 256);
      3'd3:    return 8'((ia - ib + 256) % 256);
      3'd4:    return 8'(ia * ib);
      3'd5:    return (ib == 0) ? 8'h00 : 8'(ia / ib);
      default: return 8'h00;
    endcase
  endfunction

  // ALU model: ALU_LAT register stages.
  always @(posedge clk) begin
    pipe[0] <= alu_fn(alu_op, alu_ui[7:4], alu_ui[3:0]);
    for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_result = pipe[ALU_LAT-1];

  function automatic exp_t exp_of(input logic [2:0] op, input logic [3:0] a, b);
    exp_t e;
    e.op = op;
    if (op >= 3'd6) begin
      e.data = 8'h00;
      e.err  = 1'b1;
`ifdef ALU_DIV_GUARD_EN
    end else if (op == OP_DIV && b == 4'd0) begin
      e.data = 8'hFF;
      e.err  = 1'b1;
`endif
    end else begin
      e.data = alu_fn(op, a, b);
      e.err  = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every presented response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        check("rsp", 32'({bus.rsp_op, bus.rsp_data, bus.rsp_err}), 32'(exp_q[0]));
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic offer(input logic [2:0] op, input logic [3:0] a, b, output bit acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(negedge clk);
    acc = bus.cmd_ready;
    if (acc) exp_q.push_back(exp_of(op, a, b));
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] a, b);
    bit acc;
    int n;
    acc = 0;
    n   = 0;
    while (!acc && n < 100) begin
      offer(op, a, b, acc);
      n++;
    end
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.rsp_valid !== 1'b1 && n < 200);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("drain_timeout", 32'({busy, 8'(exp_q.size())}), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n, acc_cnt;
    bit  acc;

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b1;
    #12;
    check("reset_outputs", 32'({bus.rsp_valid, bus.rsp_data, bus.rsp_op, bus.rsp_err,
                                alu_ui, alu_op, busy}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // ADD 3+5: drive pins, result ALU_LAT+1 edges after drive (ALU_LAT+3 negedges from accept).
    send(OP_ADD, 4'd3, 4'd5);
    wait_rsp(n);
    check("t1_latency", 32'(n), 32'(ALU_LAT + 3));
    check("t1_alu_pins", 32'({alu_ui, alu_op}), 32'({8'h35, 3'b010}));
    drain();

    // Illegal opcode leaves the ALU pins from the previous issue.
    send(3'b111, 4'd4, 4'd4);
    drain();
    check("t4_alu_pins", 32'({alu_ui, alu_op}), 32'({8'h35, 3'b010}));

    // SUB then MUL back to back; second response follows with no idle bubble.
    send(OP_SUB, 4'd2, 4'd5);
    send(OP_MUL, 4'd15, 4'd15);
    wait_rsp(n);
    wait_rsp(n);
    check("t2_gap", 32'(n), 32'(ALU_LAT + 2));
    drain();
    check("t2_alu_pins", 32'({alu_ui, alu_op}), 32'({8'hFF, 3'b100}));

    // DIV by zero.
    send(OP_DIV, 4'd9, 4'd0);
    drain();
`ifdef ALU_DIV_GUARD_EN
    check("t5_alu_pins", 32'({alu_ui, alu_op}), 32'({8'hFF, 3'b100}));
`else
    check("t5_alu_pins", 32'({alu_ui, alu_op}), 32'({8'h90, 3'b101}));
`endif

    // Stalled consumer: capacity DEPTH+1, responses stay stable while stalled.
    bus.rsp_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      offer(3'($urandom_range(0, 5)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), acc);
      acc_cnt += int'(acc);
    end
    check("t3_accepted", 32'(acc_cnt), 32'(DEPTH + 1));
    check("t3_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    drain();

    // Randomized traffic with a randomly stalling consumer.
    rand_on = 1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          bus.rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 40; i++)
      send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    rand_on = 0;
    @(posedge clk);
    #2;
    bus.rsp_ready = 1'b1;
    drain();

    // Reset during WAIT with three commands still queued.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(3'($urandom_range(0, 5)), 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)));
    wait_rsp(n);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_reset_outputs", 32'({bus.rsp_valid, bus.rsp_data, bus.rsp_op, bus.rsp_err,
                                   alu_ui, alu_op, busy}), 32'd0);
    check("t6_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_idle_after_reset", 32'({busy, bus.rsp_valid}), 32'd0);
    @(posedge clk);
    #1;
    send(OP_OR, 4'd10, 4'd5);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
